seq_mag_comparator: RTL
=======================

SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there are no other clocks or asynchronous controls.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand width in bits.
REQ-003 Parameter DIGIT, default 2, SHALL set the bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a compare; accepted only when busy=0.
REQ-007 A  input  WIDTH  operand A; sampled only on an accepted start.
REQ-008 B  input  WIDTH  operand B; sampled only on an accepted start.
REQ-009 signed_mode  input  1  1 = two's-complement compare; sampled with A and B; the port exists only when SEQ_CMP_SIGNED_EN is defined.
REQ-010 busy  output  1  high while a compare is in progress.
REQ-011 done  output  1  one-cycle pulse; the result flags are valid from this cycle.
REQ-012 A_less_B, A_equal_B, A_greater_B  output  1 each  registered result flags.

Function
REQ-013 The state machine SHALL have three states:
- IDLE to SCAN on an accepted start;
- SCAN to DONE on the first unequal digit or after the last digit;
- DONE to IDLE unconditionally, or DONE to SCAN on an accepted start.
REQ-014 busy SHALL be 1 in SCAN only.
REQ-015 On an accepted start, the block SHALL latch A, B and signed_mode, and set the digit index to the most significant digit (WIDTH/DIGIT-1).
REQ-016 In SCAN, the block SHALL compare one DIGIT-wide slice per cycle, MSB first.
- Unequal slice: resolve less/greater from that slice and go to DONE (early exit).
- Equal slice: decrement the index.
- Equal at index 0: result is equal.
REQ-017 Latency from an accepted start to done SHALL be k+1 cycles, where k is the 1-based position, counted from the MSB, of the first differing digit (k = WIDTH/DIGIT when the operands are equal).
REQ-018 done SHALL be high exactly in the DONE cycle.
REQ-019 The result flags SHALL update on entry to DONE, be exactly one-hot, and hold until the next DONE.
REQ-020 A start while busy=1 SHALL be ignored, with no effect on the operands or the index.
REQ-021 A start in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-022 Changes on A, B or signed_mode after acceptance SHALL NOT affect the result.

Reset
REQ-023 rst SHALL force IDLE, busy=0, done=0, and all three result flags to 0, including mid-SCAN; a start in the same cycle as rst SHALL be ignored.
REQ-024 After reset, the result flags SHALL remain all-zero until the first DONE.

Configuration
REQ-025 With SEQ_CMP_SIGNED_EN defined, when the latched signed_mode=1 the MSB of each latched operand SHALL be inverted before scanning, which gives a two's-complement ordering.
REQ-026 Without SEQ_CMP_SIGNED_EN, the signed_mode port and its logic SHALL be absent and all compares SHALL be unsigned.

Structure
REQ-027 The shared package SHALL hold the state enumeration (IDLE, SCAN, DONE) and the default constants for WIDTH and DIGIT.
REQ-028 One sub-module, cmp_slice, SHALL be instantiated once: a combinational DIGIT-bit less/equal/greater comparator with parameter DIGIT.
REQ-029 The digit index counter SHALL be clog2(WIDTH/DIGIT) bits wide, with a minimum of 1.

Verification (WIDTH=8, DIGIT=2)
REQ-030 A=0x5A, B=0x5A, start -> busy for 4 cycles, done in cycle 5, A_equal_B=1.
REQ-031 A=0x80, B=0x7F, unsigned -> done in cycle 2, A_greater_B=1; the same operands with signed_mode=1 -> done in cycle 2, A_less_B=1.
REQ-032 A=0x12, B=0x13 -> done in cycle 5, A_less_B=1; a start with A=0x00 pulsed in cycle 2 is ignored.
REQ-033 Start with A=0xFF, B=0x00, then a second start in the DONE cycle with A=0x01, B=0x02 -> both results are correct, with no idle cycle between them.
REQ-034 Assert rst in cycle 2 of a scan -> next cycle busy=0, done=0, all flags 0; a new compare then completes normally.

Source files
------------

// File: rtl/seq_mag_comparator_pkg.sv
// +--------------------------------------------------------------------------+
// | seq_mag_comparator_pkg : state encoding and default sizing               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package seq_mag_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int DIGIT_DEF = 2;

  // Index counter width; a single-digit compare still needs one bit.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mag_comparator_cmp_slice.sv
// +--------------------------------------------------------------------------+
// | cmp_slice : combinational DIGIT-bit less/equal/greater comparator        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cmp_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  assign lt_o = (a_i <  b_i);
  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

`default_nettype wire

// File: rtl/seq_mag_comparator.sv
// +--------------------------------------------------------------------------+
// | seq_mag_comparator : digit-serial MSB-first magnitude comparator with    |
// | early exit; define SEQ_CMP_SIGNED_EN to add the signed_mode port. Rev 1.0|
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SEQ_CMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             A_less_B,
  output logic             A_equal_B,
  output logic             A_greater_B
);

  localparam int                c_NDIG    = WIDTH / DIGIT;
  localparam int                c_IDXW    = idx_width(c_NDIG);
  localparam logic [c_IDXW-1:0] c_IDX_MSB = c_IDXW'(c_NDIG - 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [c_IDXW-1:0]   idx_q;
  logic                lt_q, eq_q, gt_q;
  logic [WIDTH-1:0]    w_a_eff, w_b_eff;
  logic [DIGIT-1:0]    w_a_dig, w_b_dig;
  logic                w_slc_lt, w_slc_eq, w_slc_gt;
  logic                w_accept;

  assign w_accept = start && (state_q != SCAN);

`ifdef SEQ_CMP_SIGNED_EN
  logic sm_q;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    w_a_eff = a_q;
    w_b_eff = b_q;
    if (sm_q) begin
      w_a_eff[WIDTH-1] = ~a_q[WIDTH-1];
      w_b_eff[WIDTH-1] = ~b_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           sm_q <= 1'b0;
    else if (w_accept) sm_q <= signed_mode;
  end
`else
  assign w_a_eff = a_q;
  assign w_b_eff = b_q;
`endif

  assign w_a_dig = w_a_eff[idx_q*DIGIT +: DIGIT];
  assign w_b_dig = w_b_eff[idx_q*DIGIT +: DIGIT];

  cmp_slice #(
    .DIGIT (DIGIT)
  ) u_cmp_slice (
    .a_i  (w_a_dig),
    .b_i  (w_b_dig),
    .lt_o (w_slc_lt),
    .eq_o (w_slc_eq),
    .gt_o (w_slc_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (!w_slc_eq || (idx_q == '0)) state_d = DONE;
      DONE:    state_d = start ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  // Operands, index and result flags; flags only change on the edge into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else if (w_accept) begin
      a_q   <= A;
      b_q   <= B;
      idx_q <= c_IDX_MSB;
    end else if (state_q == SCAN) begin
      if (!w_slc_eq) begin
        lt_q <= w_slc_lt;
        eq_q <= 1'b0;
        gt_q <= w_slc_gt;
      end else if (idx_q == '0) begin
        lt_q <= 1'b0;
        eq_q <= 1'b1;
        gt_q <= 1'b0;
      end else begin
        idx_q <= idx_q - c_IDXW'(1);
      end
    end
  end

  assign A_less_B    = lt_q;
  assign A_equal_B   = eq_q;
  assign A_greater_B = gt_q;

endmodule

`default_nettype wire
